// File: rtl/pinky_prog_loader_pkg.sv
// Shared types and constants for the PinKY instruction-memory loader.
package pinky_prog_loader_pkg;

  localparam int unsigned WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  // Loader FSM states (3-bit encoding)
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_DATA_HI = 3'd3,
    ST_DATA_LO = 3'd4,
    ST_CSUM    = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERR     = 3'd7
  } ld_state_t;

  // Opcode patterns used when building test images
  localparam word_t OP_SYS = 16'h9800;
  localparam word_t OP_NOP = 16'h0000;

  // States in which a stream byte is consumed
  function automatic logic state_takes_byte(input ld_state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA_HI) ||
           (s == ST_DATA_LO) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/pinky_prog_loader_byte_pair.sv
// Assembles {hi,lo} byte pairs into instruction words and registers the
// instmem write strobe, address and data.
module pinky_prog_loader_byte_pair
  import pinky_prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_hi_we,
  input  logic        i_lo_we,
  input  logic [7:0]  i_byte,
  input  word_t       i_addr,
  output logic        o_we,
  output word_t       o_addr,
  output word_t       o_wdata
);

  logic [7:0] r_hi;
  logic       r_we;
  word_t      r_addr;
  word_t      r_wdata;

  // Latch the high byte; on a low byte, register a one-cycle write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi    <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= i_lo_we;
      if (i_hi_we) begin
        r_hi <= i_byte;
      end
      if (i_lo_we) begin
        r_addr  <= i_addr;
        r_wdata <= {r_hi, i_byte};
      end
    end
  end

  assign o_we    = r_we;
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;

endmodule

// File: rtl/pinky_prog_loader.sv
// PinKY program loader: parses a framed byte stream (length, words,
// checksum), writes words to instmem and holds the CPU until done.
module pinky_prog_loader
  import pinky_prog_loader_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int unsigned MAX_WORDS = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam logic [16:0] MAXW = 17'(MAX_WORDS);

  ld_state_t   r_state;
  ld_state_t   w_next;
  logic [7:0]  r_sum;
  logic [7:0]  r_len_hi;
  word_t       r_len;
  logic [16:0] r_idx;

  logic        w_take;
  logic        w_start;
  logic        w_hi_we;
  logic        w_lo_we;
  logic        w_last;
  word_t       w_n;
  logic [7:0]  w_sum_nx;
  word_t       w_addr;

  assign w_take   = in_valid & in_ready;
  assign w_n      = {r_len_hi, in_data};
  assign w_sum_nx = r_sum + in_data;
  // Count is one bit wider than the length so N=65535 still terminates
  assign w_last   = ((r_idx + 17'd1) == {1'b0, r_len});
  assign w_addr   = BASE_ADDR + r_idx[15:0];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and output decode
  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    in_ready = state_takes_byte(r_state);
    cpu_hold = (r_state != ST_DONE);
    done     = (r_state == ST_DONE);
    err      = (r_state == ST_ERR);
    w_hi_we  = w_take && (r_state == ST_DATA_HI);
    w_lo_we  = w_take && (r_state == ST_DATA_LO);
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          w_start = 1'b1;
          w_next  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (w_take) w_next = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (w_take) begin
          if (w_n == '0)                w_next = ST_CSUM;
          else if ({1'b0, w_n} > MAXW)  w_next = ST_ERR;
          else                          w_next = ST_DATA_HI;
        end
      end
      ST_DATA_HI: begin
        if (w_take) w_next = ST_DATA_LO;
      end
      ST_DATA_LO: begin
        if (w_take) w_next = w_last ? ST_CSUM : ST_DATA_HI;
      end
      ST_CSUM: begin
        if (w_take) w_next = (w_sum_nx == 8'h00) ? ST_DONE : ST_ERR;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Length capture, running checksum and word index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sum    <= '0;
      r_len_hi <= '0;
      r_len    <= '0;
      r_idx    <= '0;
    end else if (w_start) begin
      r_sum <= '0;
      r_idx <= '0;
    end else if (w_take) begin
      r_sum <= w_sum_nx;
      case (r_state)
        ST_LEN_HI:  r_len_hi <= in_data;
        ST_LEN_LO:  r_len    <= w_n;
        ST_DATA_LO: r_idx    <= r_idx + 17'd1;
        default:    ;
      endcase
    end
  end

  pinky_prog_loader_byte_pair u_pair (
    .clk     (clk),
    .reset   (reset),
    .i_hi_we (w_hi_we),
    .i_lo_we (w_lo_we),
    .i_byte  (in_data),
    .i_addr  (w_addr),
    .o_we    (mem_we),
    .o_addr  (mem_addr),
    .o_wdata (mem_wdata)
  );

endmodule

// File: tb/tb_pinky_prog_loader.sv
// Directed bench for pinky_prog_loader: two instances (default and
// BASE_ADDR=FFFF/MAX_WORDS=2) driven from one shared byte stream.
module tb_pinky_prog_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;

  logic        d1_rdy, d1_we, d1_hold, d1_done, d1_err;
  logic [15:0] d1_addr, d1_wdata;
  logic        d2_rdy, d2_we, d2_hold, d2_done, d2_err;
  logic [15:0] d2_addr, d2_wdata;

  int total = 0;
  int bad   = 0;
  bit rnd   = 1'b0;

  logic [31:0] wq1[$];
  logic [31:0] wq2[$];

  logic [7:0] f2[$]  = '{8'h00, 8'h02, 8'h40, 8'h12, 8'h98, 8'h00, 8'h14};
  logic [7:0] f3[$]  = '{8'h00, 8'h02, 8'h40, 8'h12, 8'h98, 8'h00, 8'h15};
  logic [7:0] f0[$]  = '{8'h00, 8'h00, 8'h00};
  logic [7:0] fov[$] = '{8'h00, 8'h03};
  logic [7:0] fpt[$] = '{8'h00, 8'h02, 8'h40, 8'h12, 8'h98};

  always #5 clk = ~clk;

  pinky_prog_loader u_dut1 (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(d1_rdy), .mem_we(d1_we),
    .mem_addr(d1_addr), .mem_wdata(d1_wdata), .cpu_hold(d1_hold),
    .done(d1_done), .err(d1_err)
  );

  pinky_prog_loader #(.BASE_ADDR(16'hFFFF), .MAX_WORDS(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(d2_rdy), .mem_we(d2_we),
    .mem_addr(d2_addr), .mem_wdata(d2_wdata), .cpu_hold(d2_hold),
    .done(d2_done), .err(d2_err)
  );

  // Capture every write strobe away from the active edge
  always @(negedge clk) begin
    if (d1_we) wq1.push_back({d1_addr, d1_wdata});
    if (d2_we) wq2.push_back({d2_addr, d2_wdata});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_DEAD;
  endfunction

  task automatic send(input logic [7:0] b);
    int n = 0;
    forever begin
      @(negedge clk);
      start = 1'b0;
      if (rnd && ($urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = b;
        if (d1_rdy) begin
          @(posedge clk);
          break;
        end
      end
      n++;
      if (n > 100) begin
        check("send_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] f[$]);
    foreach (f[i]) send(f[i]);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
  endtask

  task automatic do_start(input logic wv, input logic [7:0] b);
    @(negedge clk);
    start    = 1'b1;
    in_valid = wv;
    in_data  = b;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rdy"},   {31'd0, d1_rdy},  32'd0);
    check({tag, "_we"},    {31'd0, d1_we},   32'd0);
    check({tag, "_addr"},  {16'd0, d1_addr}, 32'd0);
    check({tag, "_wdata"}, {16'd0, d1_wdata}, 32'd0);
    check({tag, "_hold"},  {31'd0, d1_hold}, 32'd1);
    check({tag, "_done"},  {31'd0, d1_done}, 32'd0);
    check({tag, "_err"},   {31'd0, d1_err},  32'd0);
    check({tag, "_addr2"}, {16'd0, d2_addr}, 32'd0);
  endtask

  task automatic check_two_writes(input string tag);
    check({tag, "_n1"}, wq1.size(), 32'd2);
    check({tag, "_w0"}, qget(wq1, 0), 32'h0000_4012);
    check({tag, "_w1"}, qget(wq1, 1), 32'h0001_9800);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    check_idle_outputs("rst");
    reset = 1'b1;

    // Bytes offered in IDLE are ignored
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h55;
    repeat (3) @(negedge clk);
    check("idle_rdy", {31'd0, d1_rdy}, 32'd0);
    check("idle_nowr", wq1.size(), 32'd0);
    in_valid = 1'b0;

    // Two-word image, good checksum; dut2 checks address wrap
    do_start(1'b0, 8'h00);
    send_frame(f2);
    check_two_writes("t2");
    check("t2_done", {31'd0, d1_done}, 32'd1);
    check("t2_hold", {31'd0, d1_hold}, 32'd0);
    check("t2_err",  {31'd0, d1_err},  32'd0);
    check("t2_rdy",  {31'd0, d1_rdy},  32'd0);
    check("t5_n2", wq2.size(), 32'd2);
    check("t5_w0", qget(wq2, 0), 32'hFFFF_4012);
    check("t5_w1", qget(wq2, 1), 32'h0000_9800);
    check("t5_done", {31'd0, d2_done}, 32'd1);

    // Bad checksum
    wq1.delete(); wq2.delete();
    do_start(1'b0, 8'h00);
    send_frame(f3);
    check_two_writes("t3");
    check("t3_err",  {31'd0, d1_err},  32'd1);
    check("t3_done", {31'd0, d1_done}, 32'd0);
    check("t3_hold", {31'd0, d1_hold}, 32'd1);

    // Empty image, then restart with the two-word image
    wq1.delete(); wq2.delete();
    do_start(1'b0, 8'h00);
    send_frame(f0);
    check("t4_nowr", wq1.size(), 32'd0);
    check("t4_done", {31'd0, d1_done}, 32'd1);
    check("t4_err",  {31'd0, d1_err},  32'd0);
    do_start(1'b0, 8'h00);
    send_frame(f2);
    check_two_writes("t4r");
    check("t4r_done", {31'd0, d1_done}, 32'd1);

    // Length above MAX_WORDS on dut2 only
    do_start(1'b0, 8'h00);
    send_frame(fov);
    check("ov_err2", {31'd0, d2_err}, 32'd1);
    check("ov_rdy2", {31'd0, d2_rdy}, 32'd0);
    check("ov_err1", {31'd0, d1_err}, 32'd0);
    check("ov_rdy1", {31'd0, d1_rdy}, 32'd1);

    // Reset while waiting for a LO byte
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    wq1.delete(); wq2.delete();
    do_start(1'b0, 8'h00);
    foreach (fpt[i]) send(fpt[i]);
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h00;
    reset = 1'b0;
    #1;
    check_idle_outputs("t1");
    check("t1_prewr", wq1.size(), 32'd1);
    @(negedge clk); reset = 1'b1;
    repeat (4) @(negedge clk);
    check("t1_nowr", wq1.size(), 32'd1);
    check("t1_rdy", {31'd0, d1_rdy}, 32'd0);
    in_valid = 1'b0;

    // Random valid gaps; start and a byte together in IDLE
    wq1.delete(); wq2.delete();
    rnd = 1'b1;
    do_start(1'b1, 8'h00);
    send_frame(f2);
    check_two_writes("t6");
    check("t6_done", {31'd0, d1_done}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
